// File: rtl/fpga_reg_bank_if.sv
// BRAM-controller style register port between the PCIe BAR window and fpga_reg_bank.
// The master drives the access; the slave returns registered read data.
interface fpga_reg_bank_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              bram_en_a;
    logic [3:0]        bram_we_a;
    logic [ADDR_W-1:0] bram_addr_a;
    logic [31:0]       bram_wrdata_a;
    logic [31:0]       bram_rddata_a;

    modport master (
        output bram_en_a,
        output bram_we_a,
        output bram_addr_a,
        output bram_wrdata_a,
        input  bram_rddata_a
    );

    modport slave (
        input  bram_en_a,
        input  bram_we_a,
        input  bram_addr_a,
        input  bram_wrdata_a,
        output bram_rddata_a
    );
endinterface

// File: rtl/fpga_reg_bank.sv
// Host-visible control/status register bank on user_clk with byte-lane writes and 2-cycle reads.
// Define FPGA_REG_PULSE_EN to make control indices PULSE_BASE..NUM_CTRL-1 self-clearing.
module fpga_reg_bank #(
    parameter int unsigned NUM_CTRL    = 512,
    parameter int unsigned NUM_STAT    = 512,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned PULSE_BASE  = 480,
    parameter logic [31:0] BAD_RD_DATA = 32'hBADA_DD00,
    localparam int unsigned CIDX_W     = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1
) (
    input  logic                      user_clk,
    input  logic                      user_aresetn,
    fpga_reg_bank_if.slave            bram,
    output logic [NUM_CTRL-1:0][31:0] fpga_control_reg,
    input  logic [NUM_STAT-1:0][31:0] fpga_status_reg,
    output logic                      ctrl_wr_valid,
    output logic [CIDX_W-1:0]         ctrl_wr_index,
    output logic [15:0]               bad_access_cnt
);

    localparam int unsigned IDX_W  = ADDR_W - 2;
    localparam int unsigned SIDX_W = (NUM_STAT > 1) ? $clog2(NUM_STAT) : 1;
    localparam int unsigned LANES  = 4;

    logic [NUM_CTRL-1:0][31:0] ctrl_mem;
    logic [NUM_CTRL-1:0][31:0] ctrl_mem_nxt_c;
    logic [NUM_STAT-1:0][31:0] stat_q;

    logic [31:0]       rd_q;
    logic              rd_pend_q;
    logic              wr_pend_q;
    logic [CIDX_W-1:0] wr_idx_q;

    logic [IDX_W-1:0]  idx_c;
    logic [31:0]       idx32_c;
    logic [CIDX_W-1:0] cidx_c;
    logic [SIDX_W-1:0] sidx_c;
    logic              is_ctrl_c;
    logic              is_stat_c;
    logic              is_pulse_c;
    logic              is_wr_c;
    logic              wr_ctrl_c;
    logic              rd_acc_c;
    logic              bad_c;
    logic [31:0]       rd_data_c;
    logic              unused_c;

    // Address decode into control / status / invalid windows
    assign idx_c     = bram.bram_addr_a[ADDR_W-1:2];
    assign idx32_c   = 32'(idx_c);
    assign cidx_c    = CIDX_W'(idx32_c);
    assign sidx_c    = SIDX_W'(idx32_c - NUM_CTRL);
    assign is_ctrl_c = (idx32_c < NUM_CTRL);
    assign is_stat_c = !is_ctrl_c && (idx32_c < (NUM_CTRL + NUM_STAT));
    assign is_wr_c   = |bram.bram_we_a;
    assign wr_ctrl_c = bram.bram_en_a && is_wr_c && is_ctrl_c;
    assign rd_acc_c  = bram.bram_en_a && !is_wr_c;
    assign bad_c     = bram.bram_en_a && ((!is_ctrl_c && !is_stat_c) || (is_stat_c && is_wr_c));

`ifdef FPGA_REG_PULSE_EN
    assign is_pulse_c = is_ctrl_c && (idx32_c >= PULSE_BASE);
`else
    assign is_pulse_c = 1'b0;
`endif

    // Byte addresses are word aligned; PULSE_BASE only matters in the pulse build
    assign unused_c = ^{bram.bram_addr_a[1:0], 32'(PULSE_BASE)};

    // Next control contents: pulse registers fall back to zero unless rewritten this cycle
    always_comb begin
        ctrl_mem_nxt_c = ctrl_mem;
`ifdef FPGA_REG_PULSE_EN
        for (int unsigned k = PULSE_BASE; k < NUM_CTRL; k++) begin
            ctrl_mem_nxt_c[CIDX_W'(k)] = '0;
        end
`endif
        if (wr_ctrl_c) begin
            for (int b = 0; b < int'(LANES); b++) begin
                if (bram.bram_we_a[2'(b)]) begin
                    ctrl_mem_nxt_c[cidx_c][8*b +: 8] = bram.bram_wrdata_a[8*b +: 8];
                end
            end
        end
    end

    // Read mux; pulse registers read back as zero since they have already cleared
    always_comb begin
        rd_data_c = BAD_RD_DATA;
        if (is_ctrl_c) begin
            rd_data_c = is_pulse_c ? 32'h0 : ctrl_mem[cidx_c];
        end else if (is_stat_c) begin
            rd_data_c = stat_q[sidx_c];
        end
    end

    always_ff @(posedge user_clk) begin
        if (!user_aresetn) begin
            ctrl_mem           <= '0;
            fpga_control_reg   <= '0;
            stat_q             <= '0;
            rd_q               <= '0;
            rd_pend_q          <= 1'b0;
            bram.bram_rddata_a <= '0;
            wr_pend_q          <= 1'b0;
            wr_idx_q           <= '0;
            ctrl_wr_valid      <= 1'b0;
            ctrl_wr_index      <= '0;
            bad_access_cnt     <= '0;
        end else begin
            ctrl_mem         <= ctrl_mem_nxt_c;
            fpga_control_reg <= ctrl_mem;
            stat_q           <= fpga_status_reg;

            // Two-stage read pipeline; output holds until the next read completes
            rd_pend_q <= rd_acc_c;
            if (rd_acc_c) begin
                rd_q <= rd_data_c;
            end
            if (rd_pend_q) begin
                bram.bram_rddata_a <= rd_q;
            end

            // Write notification lines up with fpga_control_reg
            wr_pend_q <= wr_ctrl_c;
            if (wr_ctrl_c) begin
                wr_idx_q <= cidx_c;
            end
            ctrl_wr_valid <= wr_pend_q;
            if (wr_pend_q) begin
                ctrl_wr_index <= wr_idx_q;
            end

            if (bad_c && (bad_access_cnt != 16'hFFFF)) begin
                bad_access_cnt <= bad_access_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fpga_reg_bank.sv
// Directed bench for fpga_reg_bank with a reduced 16+16 register map so the invalid window is reachable.
module tb_fpga_reg_bank;

    localparam int unsigned NUM_CTRL   = 16;
    localparam int unsigned NUM_STAT   = 16;
    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned PULSE_BASE = 12;
    localparam int unsigned BAD_IDX    = NUM_CTRL + NUM_STAT;

`ifdef FPGA_REG_PULSE_EN
    localparam logic [31:0] PULSE_LATE_EXP = 32'h0;
    localparam logic [31:0] PULSE_RD_EXP   = 32'h0;
`else
    localparam logic [31:0] PULSE_LATE_EXP = 32'h1;
    localparam logic [31:0] PULSE_RD_EXP   = 32'h1;
`endif

    logic                      user_clk;
    logic                      user_aresetn;
    logic [NUM_CTRL-1:0][31:0] ctrl_reg;
    logic [NUM_STAT-1:0][31:0] stat_reg;
    logic                      wr_valid;
    logic [3:0]                wr_index;
    logic [15:0]               bad_cnt;

    int n_run;
    int n_fail;

    fpga_reg_bank_if #(.ADDR_W(ADDR_W)) bus ();

    fpga_reg_bank #(
        .NUM_CTRL   (NUM_CTRL),
        .NUM_STAT   (NUM_STAT),
        .ADDR_W     (ADDR_W),
        .PULSE_BASE (PULSE_BASE),
        .BAD_RD_DATA(32'hBADA_DD00)
    ) dut (
        .user_clk        (user_clk),
        .user_aresetn    (user_aresetn),
        .bram            (bus.slave),
        .fpga_control_reg(ctrl_reg),
        .fpga_status_reg (stat_reg),
        .ctrl_wr_valid   (wr_valid),
        .ctrl_wr_index   (wr_index),
        .bad_access_cnt  (bad_cnt)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge user_clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [3:0] we, input int unsigned idx,
                         input logic [31:0] d);
        bus.bram_en_a     = en;
        bus.bram_we_a     = we;
        bus.bram_addr_a   = ADDR_W'(idx << 2);
        bus.bram_wrdata_a = d;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 0, 32'h0);
    endtask

    initial begin
        n_run        = 0;
        n_fail       = 0;
        user_aresetn = 1'b0;
        stat_reg     = '0;
        idle();
        step(); step(); step();
        user_aresetn = 1'b1;

        check("rst_rddata", bus.bram_rddata_a, 32'h0);
        check("rst_wr_valid", 32'(wr_valid), 32'h0);
        check("rst_bad_cnt", 32'(bad_cnt), 32'h0);
        check("rst_ctrl5", ctrl_reg[5], 32'h0);

        // Read of a never-written control register
        drive(1'b1, 4'h0, 5, 32'h0); step();
        idle(); step();
        check("rd_ctrl5", bus.bram_rddata_a, 32'h0);

        // Full write, then lane write with we=0101: lanes 0 and 2 take new bytes
        drive(1'b1, 4'hF, 3, 32'h1122_3344); step();
        drive(1'b1, 4'b0101, 3, 32'hAABB_CCDD); step();
        idle();
        check("ctrl3_first", ctrl_reg[3], 32'h1122_3344);
        check("wr_valid_first", 32'(wr_valid), 32'h1);
        step();
        check("ctrl3_lanes", ctrl_reg[3], 32'h11BB_33DD);
        check("wr_valid_second", 32'(wr_valid), 32'h1);
        check("wr_index_3", 32'(wr_index), 32'h3);
        step();
        check("wr_valid_drop", 32'(wr_valid), 32'h0);
        drive(1'b1, 4'h0, 3, 32'h0); step();
        idle(); step();
        check("rd_ctrl3", bus.bram_rddata_a, 32'h11BB_33DD);

        // Status read, then a change that is one cycle too late for the next read
        stat_reg[7] = 32'hCAFE_0007;
        step(); step();
        drive(1'b1, 4'h0, NUM_CTRL + 7, 32'h0); step();
        idle(); step();
        check("rd_stat7", bus.bram_rddata_a, 32'hCAFE_0007);
        stat_reg[7] = 32'hDEAD_BEEF;
        drive(1'b1, 4'h0, NUM_CTRL + 7, 32'h0); step();
        idle(); step();
        check("rd_stat7_lag", bus.bram_rddata_a, 32'hCAFE_0007);
        drive(1'b1, 4'h0, NUM_CTRL + 7, 32'h0); step();
        idle(); step();
        check("rd_stat7_new", bus.bram_rddata_a, 32'hDEAD_BEEF);

        // Write to status is dropped and counted
        drive(1'b1, 4'hF, NUM_CTRL + 7, 32'h0123_4567); step();
        idle(); step();
        check("bad_cnt_stat_wr", 32'(bad_cnt), 32'h1);
        check("stat_wr_no_valid", 32'(wr_valid), 32'h0);

        // Invalid index read
        drive(1'b1, 4'h0, BAD_IDX, 32'h0); step();
        idle(); step();
        check("rd_bad", bus.bram_rddata_a, 32'hBADA_DD00);
        check("bad_cnt_rd", 32'(bad_cnt), 32'h2);

        // Back-to-back write/read/read every cycle
        drive(1'b1, 4'hF, 1, 32'h1357_9BDF); step();
        drive(1'b1, 4'hF, 0, 32'h0A0B_0C0D); step();
        drive(1'b1, 4'h0, 0, 32'h0); step();
        check("b2b_wr_valid", 32'(wr_valid), 32'h1);
        check("b2b_wr_index", 32'(wr_index), 32'h0);
        check("b2b_hold_bad", bus.bram_rddata_a, 32'hBADA_DD00);
        drive(1'b1, 4'h0, 1, 32'h0); step();
        check("b2b_rd0", bus.bram_rddata_a, 32'h0A0B_0C0D);
        drive(1'b1, 4'hF, 2, 32'hFFFF_FFFF); step();
        check("b2b_rd1", bus.bram_rddata_a, 32'h1357_9BDF);
        idle(); step(); step();
        check("wr_no_disturb", bus.bram_rddata_a, 32'h1357_9BDF);
        check("ctrl2", ctrl_reg[2], 32'hFFFF_FFFF);

        // Pulse register behaviour (sticky when the feature is off)
        drive(1'b1, 4'hF, PULSE_BASE, 32'h1); step();
        idle(); step();
        check("pulse_hi", ctrl_reg[PULSE_BASE], 32'h1);
        step();
        check("pulse_after", ctrl_reg[PULSE_BASE], PULSE_LATE_EXP);
        drive(1'b1, 4'h0, PULSE_BASE, 32'h0); step();
        idle(); step();
        check("pulse_rd", bus.bram_rddata_a, PULSE_RD_EXP);
        drive(1'b1, 4'hF, PULSE_BASE, 32'h1); step();
        idle(); step();
        check("repulse_hi", ctrl_reg[PULSE_BASE], 32'h1);
        step();
        check("repulse_after", ctrl_reg[PULSE_BASE], PULSE_LATE_EXP);

        // Counter saturation: 2 so far plus 70000 more invalid accesses
        for (int i = 0; i < 70000; i++) begin
            drive(1'b1, (i % 2 == 0) ? 4'h0 : 4'hF, BAD_IDX + 1, 32'h0);
            step();
        end
        idle(); step();
        check("bad_cnt_sat", 32'(bad_cnt), 32'h0000_FFFF);

        // Reset arriving while a read is in flight discards it
        drive(1'b1, 4'h0, 3, 32'h0); step();
        idle();
        user_aresetn = 1'b0;
        step();
        check("rst_mid_rd", bus.bram_rddata_a, 32'h0);
        user_aresetn = 1'b1;
        step();
        check("rst_mid_rd_hold", bus.bram_rddata_a, 32'h0);
        check("rst_bad_clear", 32'(bad_cnt), 32'h0);
        check("rst_ctrl3_clear", ctrl_reg[3], 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
